// File: rtl/apb_axi_pkg.sv
// Shared types for the APB4-to-AXI4-Lite bridge: FSM state encoding and AXI response codes.
// Combinational helpers only; no latency, no flow control.
// Any non-OKAY response, EXOKAY included, is reported to APB as an error.
package apb_axi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic resp_is_err(input logic [1:0] resp);
        logic err;
        case (resp)
            RESP_OKAY:                             err = 1'b0;
            RESP_EXOKAY, RESP_SLVERR, RESP_DECERR: err = 1'b1;
            default:                               err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/apb_2_axi_lite.sv
// APB4 completer to AXI4-Lite manager: one APB transfer becomes one single-beat AXI write or read.
// Latency: PREADY rises 3 cycles after the setup edge with an immediately responding slave (2 wait states).
// Backpressure: AXI READY/VALID stalls stretch the APB access phase; PSEL loss lets AXI finish silently.
module apb_2_axi_lite
    import apb_axi_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 5,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic [AXI_ADDR_WIDTH-1:0]     PADDR,
    input  logic [2:0]                    PPROT,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    input  logic                          PWRITE,
    input  logic [AXI_DATA_WIDTH-1:0]     PWDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0]   PSTRB,
    output logic                          PREADY,
    output logic [AXI_DATA_WIDTH-1:0]     PRDATA,
    output logic                          PSLVERR,
    output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;

    state_t                      state_q,   state_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic [2:0]                  prot_q,    prot_d;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q,   wdata_d;
    logic [STRB_W-1:0]           wstrb_q,   wstrb_d;
    logic                        awvalid_q, awvalid_d;
    logic                        wvalid_q,  wvalid_d;
    logic                        bready_q,  bready_d;
    logic                        arvalid_q, arvalid_d;
    logic                        rready_q,  rready_d;
    logic                        pready_q,  pready_d;
    logic                        pslverr_q, pslverr_d;
    logic [AXI_DATA_WIDTH-1:0]   prdata_q,  prdata_d;
    logic                        abort_q,   abort_d;

    // Set once the APB side lets go of PSEL; the AXI side still runs to completion.
    logic                        aborted;
    assign aborted = abort_q | ~PSEL;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            prot_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            prot_q    <= prot_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            abort_q   <= abort_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        prot_d    = prot_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        abort_d   = abort_q;

        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (PSEL && !PENABLE) begin
                    addr_d = PADDR;
                    prot_d = PPROT;
                    if (PWRITE) begin
                        wdata_d   = PWDATA;
                        wstrb_d   = PSTRB;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end

            WR_REQ: begin
                abort_d   = aborted;
                awvalid_d = awvalid_q & ~M_AXI_AWREADY;
                wvalid_d  = wvalid_q & ~M_AXI_WREADY;
                // A channel whose VALID already dropped has handshaken earlier.
                if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end

            WR_RESP: begin
                abort_d = aborted;
                if (M_AXI_BVALID) begin
                    bready_d = 1'b0;
                    if (aborted) begin
                        state_d = IDLE;
                    end else begin
                        pready_d  = 1'b1;
                        pslverr_d = resp_is_err(M_AXI_BRESP);
                        state_d   = DONE;
                    end
                end
            end

            RD_REQ: begin
                abort_d = aborted;
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end
            end

            RD_RESP: begin
                abort_d = aborted;
                if (M_AXI_RVALID) begin
                    rready_d = 1'b0;
                    if (aborted) begin
                        state_d = IDLE;
                    end else begin
                        prdata_d  = M_AXI_RDATA;
                        pready_d  = 1'b1;
                        pslverr_d = resp_is_err(M_AXI_RRESP);
                        state_d   = DONE;
                    end
                end
            end

            DONE: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign PREADY        = pready_q;
    assign PSLVERR       = pslverr_q;
    assign PRDATA        = prdata_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = prot_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = prot_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: doc/apb_2_axi_lite.md
Name:
apb_2_axi_lite

Overview:
APB4 completer to AXI4-Lite manager bridge. It is the counterpart of axi_lite_2_apb. Each APB transfer is converted into exactly one AXI-Lite single-beat write or read, and the APB access phase is stretched with PREADY until the AXI response returns. It lets APB-side masters reach AXI-Lite register slaves on the same clock domain.

Parameters:
AXI_ADDR_WIDTH, 5, address width; PADDR is passed through to AWADDR/ARADDR unchanged.
AXI_DATA_WIDTH, 32, data width (32 or 64); strobe width is AXI_DATA_WIDTH/8.

Ports:
M_AXI_ACLK  in  1  single clock for both sides
M_AXI_ARESETN  in  1  asynchronous, active-low reset
PADDR  in  AXI_ADDR_WIDTH  APB address
PPROT  in  3  APB protection, forwarded to AWPROT/ARPROT
PSEL  in  1  completer select
PENABLE  in  1  access phase
PWRITE  in  1  1=write, 0=read
PWDATA  in  AXI_DATA_WIDTH  write data
PSTRB  in  AXI_DATA_WIDTH/8  write byte strobes
PREADY  out  1  transfer complete
PRDATA  out  AXI_DATA_WIDTH  read data
PSLVERR  out  1  error, valid with PREADY
M_AXI_AWADDR  out  AXI_ADDR_WIDTH  write address
M_AXI_AWPROT  out  3  write protection
M_AXI_AWVALID  out  1  write address valid
M_AXI_AWREADY  in  1  write address ready
M_AXI_WDATA  out  AXI_DATA_WIDTH  write data
M_AXI_WSTRB  out  AXI_DATA_WIDTH/8  write strobes
M_AXI_WVALID  out  1  write data valid
M_AXI_WREADY  in  1  write data ready
M_AXI_BRESP  in  2  write response
M_AXI_BVALID  in  1  write response valid
M_AXI_BREADY  out  1  write response ready
M_AXI_ARADDR  out  AXI_ADDR_WIDTH  read address
M_AXI_ARPROT  out  3  read protection
M_AXI_ARVALID  out  1  read address valid
M_AXI_ARREADY  in  1  read address ready
M_AXI_RDATA  in  AXI_DATA_WIDTH  read data
M_AXI_RRESP  in  2  read response
M_AXI_RVALID  in  1  read data valid
M_AXI_RREADY  out  1  read data ready

Behaviour:
- Reset state: asynchronous on M_AXI_ARESETN low. All VALID/READY outputs, PREADY and PSLVERR are 0; PRDATA, addresses, data and WSTRB are 0; FSM goes to IDLE. Reset mid-transfer abandons the transfer silently.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE. All outputs are registered.
- IDLE: on PSEL=1 and PENABLE=0 (setup phase), register PADDR, PPROT, PWDATA and PSTRB. Go to WR_REQ with AWVALID=WVALID=1 if PWRITE=1, else RD_REQ with ARVALID=1.
- WR_REQ: AWVALID and WVALID are independent. Each is held with stable payload until its own READY is seen, then drops the next cycle, in either order. When both have handshaken, go to WR_RESP with BREADY=1.
- WR_RESP: on BVALID, capture BRESP, drop BREADY and go to DONE.
- RD_REQ: hold ARVALID until ARREADY, then go to RD_RESP with RREADY=1.
- RD_RESP: on RVALID, capture RDATA into PRDATA, drop RREADY and go to DONE.
- DONE: PREADY=1 for exactly one cycle. PSLVERR = (captured RESP != 2'b00), so SLVERR, DECERR and EXOKAY all map to error. Then return to IDLE; a new setup phase may be accepted on the following cycle.
- Latency: with all AXI ready/valid signals responding immediately, PREADY rises 3 cycles after the setup edge, i.e. 2 wait states.
- PRDATA holds its last read value and is unchanged on writes. PSTRB is ignored on reads; WSTRB is updated only on writes.
- Abort rule: if PSEL drops mid-transfer, the AXI transaction still completes (AXI cannot be aborted), the result is discarded, and no PREADY is issued.
- PSEL held without a fresh setup phase while in DONE does not start a second transfer.

Decomposition:
Package apb_axi_pkg holds the state enum typedef and the resp constants RESP_OKAY, RESP_EXOKAY, RESP_SLVERR and RESP_DECERR. The block is a single module with no sub-module.

Test Plan:
1. Write PADDR=0x08, PWDATA=0xA5A50001, PSTRB=4'hF, AXI slave always ready, BRESP=OKAY -> AWADDR=0x08, WDATA=0xA5A50001, WSTRB=4'hF, PREADY on the 3rd cycle after setup, PSLVERR=0.
2. Write with AWREADY delayed 3 cycles and WREADY immediate -> WVALID high 1 cycle, AWVALID high 4 cycles, BREADY only after both handshakes, exactly one PREADY pulse.
3. Read PADDR=0x0C, RDATA=0x12345678, RRESP=2'b10, RVALID delayed 5 cycles -> PRDATA=0x12345678, PSLVERR=1 with PREADY, RREADY=1 throughout the wait.
4. Sweep: write indices 0..7 to addresses 4*i with data i+k, then read them back, for k=0..9 -> every read returns i+k, no PSLVERR, AXI checker clean.
5. Assert M_AXI_ARESETN low while in WR_REQ -> all outputs 0 immediately (asynchronous), FSM in IDLE; the next write completes normally.
6. Drop PSEL while in RD_RESP -> the RVALID/RREADY handshake completes, no PREADY pulse, FSM returns to IDLE.
